arinc429_tx_scheduler: RTL and testbench
========================================

# arinc429_tx_scheduler

Transmit scheduler that shares one `arinc429` transmitter among `NUM_REQ` word sources. It arbitrates round-robin and hands the winning 32-bit word to the transmitter with a one-cycle load pulse. It then tracks the transmitter's busy flag and enforces the ARINC 429 minimum inter-word gap before the next word may start. It sits between the label-producing logic and the transmitter's `data_in` port.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8
- `CLK_PER_BIT`, 240: `Clk` cycles per ARINC bit (24 MHz / 100 kbps)
- `GAP_BITS`, 4: minimum inter-word gap in bit times
- `Clk`  in  1  system clock, rising edge
- `Rst_n`  in  1  reset, synchronous, active-low
- `en`  in  1  scheduler enable; gates new arbitration only
- `req`  in  NUM_REQ  per-source request level; held with its word until granted
- `req_word`  in  32*NUM_REQ  flattened words; source i at [32*i+31:32*i]
- `gnt`  out  NUM_REQ  one-hot, one-cycle pulse: word of source i captured
- `tx_word`  out  32  word to transmitter; held stable from load until next load
- `tx_load`  out  1  one-cycle pulse: transmitter starts sending `tx_word`
- `tx_busy`  in  1  transmitter busy; rises one cycle after `tx_load`
- `sched_busy`  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD, WAIT_START, WAIT_DONE, GAP.
- IDLE: if `en` and `|req`, select the winner, capture its word (parity applied per Configuration), update the pointer, go to LOAD. Otherwise stay in IDLE.
- LOAD: `tx_load`=1, `gnt[winner]`=1 for exactly this cycle. Go to WAIT_START.
- WAIT_START: wait for `tx_busy`=1, then go to WAIT_DONE. There is no timeout.
- WAIT_DONE: wait for `tx_busy`=0, then go to GAP and load the gap counter with `GAP_BITS*CLK_PER_BIT`-1.
- GAP: decrement each cycle; at 0 go to IDLE.
- Round-robin rule: the pointer resets to 0. Search starts at the pointer and wraps modulo `NUM_REQ`. After granting i, the pointer becomes (i+1) mod `NUM_REQ`.
- Requests that drop before being granted are simply skipped. A request that is still high after its `gnt` is treated as a new request.
- `en` falling mid-word: the current word and its gap complete, then the block stays in IDLE. `en` is sampled only in IDLE.
- Reset values: state IDLE, `gnt`=0, `tx_load`=0, `tx_word`=0, `sched_busy`=0, pointer 0, counter 0.
- Reset asserted in any state returns the block to IDLE on the next edge. The in-flight grant is not repeated.
- Gap counter width: $clog2(`GAP_BITS*CLK_PER_BIT`). It never wraps.

## Timing
- Request latency: `req` is sampled high in IDLE at edge k. `gnt` and `tx_load` are high in the cycle after edge k.
- `tx_word` is valid in the same cycle as `tx_load` and is unchanged until the next `tx_load`.
- Gap timing, with c the first cycle in which `tx_busy`=0 is sampled:
  - GAP occupies cycles c+1..c+G, where G=`GAP_BITS*CLK_PER_BIT`.
  - IDLE occupies cycle c+G+1.
  - The earliest next `tx_load` is cycle c+G+2.
- Back-to-back throughput: one word per (transmit time + G + 3) cycles.

## Configuration
- `ARINC429_TX_PARITY_EN` defined: the captured word has bit 31 replaced by odd parity, ~^word[30:0]. All 32 bits then have odd popcount.
- `ARINC429_TX_PARITY_EN` undefined: the word passes through unchanged, with the source responsible for parity.
- Timing is identical in both builds.

## Structure
- Package `arinc429_pkg`:
  - state enum
  - `ARINC_WORD_W`=32
  - default `CLK_PER_BIT` and `GAP_BITS` constants
  - odd-parity function
- Sub-module `arinc429_rr_arbiter`: combinational one-hot winner from `req` and the pointer, plus the next-pointer output. The pointer register stays in the scheduler.

## Test plan
- Reset, then `req`=4'b0001 with word0=32'hABDCABAB:
  - parity off: `gnt`=4'b0001, `tx_load`=1, and `tx_word`=32'hABDCABAB, all one cycle after sampling.
  - parity on: `tx_word`=32'h2BDCABAB.
- `req`=4'b1111 held continuously: grants come in order 0,1,2,3,0. Each successive `tx_load` is exactly G+2 cycles after `tx_busy` falls, with G=960.
- Pointer at 2 and `req`=4'b0011: grant goes to source 0, then 1. Confirms wrap-around.
- `en` dropped during WAIT_DONE with `req` pending: the word completes and GAP runs. The block then stays in IDLE with `sched_busy`=0, and no `tx_load` occurs until `en`=1.
- `Rst_n`=0 for one cycle mid-GAP: all outputs are 0 and the pointer is 0 on the next edge. With `req`=4'b1010 asserted afterwards, source 1 is granted first.
- `tx_busy` delayed 5 cycles after `tx_load`: the block stays in WAIT_START with no extra `tx_load` or `gnt` pulses.

Source files
------------

// File: rtl/arinc429_pkg.sv
// -----------------------------------------------------------------------------
// arinc429_pkg
//   Shared types and constants for the ARINC 429 transmit scheduler.
//   - sched_state_t   : scheduler FSM states
//   - ARINC_WORD_W    : ARINC 429 word width (32)
//   - CLK_PER_BIT_DEF : default clk cycles per ARINC bit (24 MHz / 100 kbps)
//   - GAP_BITS_DEF    : default minimum inter-word gap in bit times
//   - odd_parity()    : bit value that makes a 31-bit payload plus it odd
// -----------------------------------------------------------------------------
package arinc429_pkg;

    localparam int ARINC_WORD_W    = 32;
    localparam int CLK_PER_BIT_DEF = 240;
    localparam int GAP_BITS_DEF    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_START,
        ST_WAIT_DONE,
        ST_GAP
    } sched_state_t;

    // Returns 1 when the payload has an even number of ones, so that the
    // full 32-bit word ends up with odd popcount.
    function automatic logic odd_parity(input logic [ARINC_WORD_W-2:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/arinc429_tx_scheduler_if.sv
// -----------------------------------------------------------------------------
// arinc429_tx_scheduler_if
//   Bundles the word-source and transmitter signals of the scheduler.
//   Signals:
//     en          scheduler enable (gates new arbitration)
//     req         per-source request level
//     req_word    flattened source words, source i at [32*i+31:32*i]
//     gnt         one-hot grant pulse
//     tx_word     word presented to the transmitter
//     tx_load     transmitter start pulse
//     tx_busy     transmitter busy flag
//     sched_busy  scheduler not in IDLE
//   Modports:
//     master  environment side (sources + transmitter)
//     slave   scheduler side
// -----------------------------------------------------------------------------
interface arinc429_tx_scheduler_if #(
    parameter int NUM_REQ = 4
);
    import arinc429_pkg::*;

    logic                             en;
    logic [NUM_REQ-1:0]               req;
    logic [ARINC_WORD_W*NUM_REQ-1:0]  req_word;
    logic [NUM_REQ-1:0]               gnt;
    logic [ARINC_WORD_W-1:0]          tx_word;
    logic                             tx_load;
    logic                             tx_busy;
    logic                             sched_busy;

    modport master (
        output en, req, req_word, tx_busy,
        input  gnt, tx_word, tx_load, sched_busy
    );

    modport slave (
        input  en, req, req_word, tx_busy,
        output gnt, tx_word, tx_load, sched_busy
    );

endinterface

// File: rtl/arinc429_rr_arbiter.sv
// -----------------------------------------------------------------------------
// arinc429_rr_arbiter
//   Combinational round-robin selection. The search starts at ptr and wraps
//   modulo NUM_REQ; the first active request wins. The pointer register
//   itself lives in the scheduler.
//   Ports:
//     req       in   request vector
//     ptr       in   current round-robin pointer (< NUM_REQ)
//     valid     out  at least one request active
//     gnt       out  one-hot winner
//     win_idx   out  binary index of the winner
//     next_ptr  out  (win_idx + 1) mod NUM_REQ
// -----------------------------------------------------------------------------
module arinc429_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               valid,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   win_idx,
    output logic [PTR_W-1:0]   next_ptr
);

    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        // NOTE: every output gets a value before any branch so no latch is inferred.
        valid   = 1'b0;
        gnt     = '0;
        win_idx = '0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // One extra bit holds ptr+i before the single modulo subtraction.
            sum = {1'b0, ptr} + (PTR_W+1)'(i);
            if (int'(sum) >= NUM_REQ) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!valid && req[idx]) begin
                valid    = 1'b1;
                gnt[idx] = 1'b1;
                win_idx  = idx;
            end
        end
        next_ptr = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
    end

endmodule

// File: rtl/arinc429_tx_scheduler.sv
// -----------------------------------------------------------------------------
// arinc429_tx_scheduler
//   Shares one ARINC 429 transmitter among NUM_REQ word sources. Arbitrates
//   round-robin in IDLE, hands the winning word over with a one-cycle load
//   pulse, follows the transmitter's busy flag and then holds off for the
//   minimum inter-word gap (GAP_BITS*CLK_PER_BIT cycles) before returning
//   to IDLE.
//   Build option:
//     ARINC429_TX_PARITY_EN  defined: bit 31 of the captured word is replaced
//                            by odd parity over bits 30:0; undefined: the
//                            word passes through unchanged.
//   Ports:
//     Clk    in  system clock, rising edge
//     Rst_n  in  synchronous active-low reset
//     bus    slave modport of arinc429_tx_scheduler_if (en, req, req_word,
//            tx_busy in; gnt, tx_word, tx_load, sched_busy out)
// -----------------------------------------------------------------------------
module arinc429_tx_scheduler
    import arinc429_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int CLK_PER_BIT = CLK_PER_BIT_DEF,
    parameter int GAP_BITS    = GAP_BITS_DEF
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    arinc429_tx_scheduler_if.slave  bus
);

    localparam int GAP_CYC = GAP_BITS * CLK_PER_BIT;
    localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int PTR_W   = $clog2(NUM_REQ);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

    sched_state_t              state;
    sched_state_t              state_nxt;
    logic [PTR_W-1:0]          ptr;
    logic [NUM_REQ-1:0]        gnt_q;
    logic [ARINC_WORD_W-1:0]   tx_word_q;
    logic [GAP_W-1:0]          gap_cnt;

    logic                      arb_valid;
    logic [NUM_REQ-1:0]        arb_gnt;
    logic [PTR_W-1:0]          arb_idx;
    logic [PTR_W-1:0]          arb_next_ptr;
    logic [ARINC_WORD_W-1:0]   sel_word;
    logic [ARINC_WORD_W-1:0]   cap_word;
    logic                      take_grant;

    arinc429_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req      (bus.req),
        .ptr      (ptr),
        .valid    (arb_valid),
        .gnt      (arb_gnt),
        .win_idx  (arb_idx),
        .next_ptr (arb_next_ptr)
    );

    // Word of the current winner, with parity applied when enabled.
    always_comb begin
        sel_word = bus.req_word[ARINC_WORD_W*arb_idx +: ARINC_WORD_W];
`ifdef ARINC429_TX_PARITY_EN
        cap_word = {odd_parity(sel_word[ARINC_WORD_W-2:0]), sel_word[ARINC_WORD_W-2:0]};
`else
        cap_word = sel_word;
`endif
    end

    assign take_grant = (state == ST_IDLE) && bus.en && arb_valid;

    // State register.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!Rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. en is only looked at in IDLE, so a word already in
    // flight always finishes together with its gap.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:       if (take_grant)   state_nxt = ST_LOAD;
            ST_LOAD:                         state_nxt = ST_WAIT_START;
            ST_WAIT_START: if (bus.tx_busy)  state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE:  if (!bus.tx_busy) state_nxt = ST_GAP;
            ST_GAP:        if (gap_cnt == '0) state_nxt = ST_IDLE;
            default:                         state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: pointer, latched grant, captured word and gap counter.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            ptr       <= '0;
            gnt_q     <= '0;
            tx_word_q <= '0;
            gap_cnt   <= '0;
        end else begin
            if (take_grant) begin
                ptr       <= arb_next_ptr;
                gnt_q     <= arb_gnt;
                tx_word_q <= cap_word;
            end
            // Loaded with G-1 so GAP lasts exactly G cycles; holds at zero.
            if (state == ST_WAIT_DONE && !bus.tx_busy) begin
                gap_cnt <= GAP_LOAD;
            end else if (state == ST_GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

    // Outputs are decoded from the registered state only.
    always_comb begin
        bus.tx_load    = (state == ST_LOAD);
        bus.gnt        = (state == ST_LOAD) ? gnt_q : '0;
        bus.sched_busy = (state != ST_IDLE);
    end

    assign bus.tx_word = tx_word_q;

endmodule

// File: tb/tb_arinc429_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_arinc429_tx_scheduler
//   Self-checking bench for arinc429_tx_scheduler. A timestamp-based reference
//   model (when the block may arbitrate, when a load must appear, when the gap
//   ends) predicts gnt/tx_load/tx_word/sched_busy for every cycle; a compare
//   process checks them at each falling edge. Directed scenarios add literal
//   expectations; a randomized phase follows. A simple transmitter model
//   answers tx_load with a tx_busy pulse of configurable delay and length.
// -----------------------------------------------------------------------------
module tb_arinc429_tx_scheduler;
    import arinc429_pkg::*;

    localparam int N   = 4;
    localparam int CPB = 240;
    localparam int GB  = 4;
    localparam int G   = GB * CPB;

`ifdef ARINC429_TX_PARITY_EN
    localparam logic [31:0] W0_EXP = 32'h2BDCABAB;
`else
    localparam logic [31:0] W0_EXP = 32'hABDCABAB;
`endif

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    arinc429_tx_scheduler_if #(.NUM_REQ(N)) bus ();

    arinc429_tx_scheduler #(
        .NUM_REQ     (N),
        .CLK_PER_BIT (CPB),
        .GAP_BITS    (GB)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transmitter model ----------------
    logic tx_busy_drv = 1'b0;
    int   xmit_t      = -1;
    int   xmit_delay  = 1;
    int   xmit_len    = 30;
    int   fall_cyc    = -1;
    assign bus.tx_busy = tx_busy_drv;

    // A value written at the falling edge of cycle m is what the DUT samples
    // at the end of cycle m; delay 1 means busy in the cycle after tx_load.
    always @(negedge Clk) begin
        logic prev;
        prev = tx_busy_drv;
        if (bus.tx_load === 1'b1) xmit_t = 0;
        else if (xmit_t >= 0)     xmit_t++;
        tx_busy_drv = (xmit_t >= xmit_delay) && (xmit_t < xmit_delay + xmit_len);
        if (xmit_t >= xmit_delay + xmit_len) xmit_t = -1;
        if (prev && !tx_busy_drv) fall_cyc = cyc;
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_word(input logic [31:0] w);
        logic [31:0] r;
        r = w;
`ifdef ARINC429_TX_PARITY_EN
        r[31] = ($countones(w[30:0]) % 2) == 0;
`endif
        return r;
    endfunction

    bit          model_on = 1'b0;
    bit          m_busy;
    int          m_ptr;
    int          m_load_cyc;
    bit          m_seen_busy;
    int          m_idle_at;
    logic [N-1:0] m_win;
    logic [N-1:0] e_gnt;
    logic        e_load;
    logic        e_sched;
    logic [31:0] e_word;

    // Cycle n is the cycle that starts at the n-th rising edge.
    always @(posedge Clk) begin
        int  win;
        bit  found;
        cyc++;
        if (!Rst_n) begin
            model_on    = 1'b1;
            m_busy      = 1'b0;
            m_ptr       = 0;
            m_load_cyc  = -1;
            m_seen_busy = 1'b0;
            m_idle_at   = -1;
            m_win       = '0;
            e_word      = '0;
        end else if (model_on) begin
            if (m_busy) begin
                // Cycle cyc-1 just ended; busy is only looked at after the load.
                if (cyc - 1 > m_load_cyc) begin
                    if (!m_seen_busy) begin
                        if (bus.tx_busy) m_seen_busy = 1'b1;
                    end else if (m_idle_at < 0 && !bus.tx_busy) begin
                        m_idle_at = (cyc - 1) + G + 1;
                    end
                end
                if (m_idle_at >= 0 && cyc >= m_idle_at) m_busy = 1'b0;
            end else if (bus.en && bus.req != '0) begin
                found = 1'b0;
                win   = 0;
                for (int k = 0; k < N; k++) begin
                    int s;
                    s = (m_ptr + k) % N;
                    if (!found && bus.req[s]) begin
                        found = 1'b1;
                        win   = s;
                    end
                end
                m_win       = '0;
                m_win[win]  = 1'b1;
                m_ptr       = (win + 1) % N;
                e_word      = model_word(bus.req_word[32*win +: 32]);
                m_busy      = 1'b1;
                m_load_cyc  = cyc;
                m_seen_busy = 1'b0;
                m_idle_at   = -1;
            end
        end
        e_load  = model_on && m_busy && (cyc == m_load_cyc);
        e_gnt   = e_load ? m_win : '0;
        e_sched = m_busy;
    end

    // Single compare process: every cycle once reset has been seen.
    always @(negedge Clk) begin
        if (model_on) begin
            check("gnt",        bus.gnt,        e_gnt);
            check("tx_load",    bus.tx_load,    e_load);
            check("sched_busy", bus.sched_busy, e_sched);
            check("tx_word",    bus.tx_word,    e_word);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge Clk);
    endtask

    task automatic set_word(input int i, input logic [31:0] w);
        bus.req_word[32*i +: 32] = w;
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i] && r < 0) r = i;
        return r;
    endfunction

    task automatic wait_load(output int idx, output int waited);
        idx    = -1;
        waited = 0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge Clk);
            waited++;
            if (bus.tx_load === 1'b1) begin
                idx = onehot_idx(bus.gnt);
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL load_timeout: no tx_load within 5000 cycles (cycle %0d)", cyc);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 5000; k++) begin
            @(negedge Clk);
            if (bus.sched_busy === 1'b0) return;
        end
        total++;
        bad++;
        $display("FAIL idle_timeout: sched_busy stuck high (cycle %0d)", cyc);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int idx, w, loads, sb, guard;
        int exp_seq[5];
        exp_seq = '{0, 1, 2, 3, 0};

        bus.en       = 1'b0;
        bus.req      = '0;
        bus.req_word = '0;
        Rst_n        = 1'b0;
        tick(3);
        check("rst_gnt",        bus.gnt,        4'b0000);
        check("rst_tx_load",    bus.tx_load,    1'b0);
        check("rst_sched_busy", bus.sched_busy, 1'b0);
        check("rst_tx_word",    bus.tx_word,    32'h0);
        Rst_n = 1'b1;
        tick(2);

        // Single request, one-cycle latency, parity handling.
        set_word(0, 32'hABDCABAB);
        bus.en  = 1'b1;
        bus.req = 4'b0001;
        wait_load(idx, w);
        check("A_latency", w, 1);
        check("A_gnt", bus.gnt, 4'b0001);
        check("A_word", bus.tx_word, W0_EXP);
        bus.req = '0;
        wait_idle();

        // Fresh reset, all sources held: strict rotation and exact gap.
        Rst_n = 1'b0;
        tick(1);
        Rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_word(i, $urandom);
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_load(idx, w);
            check("B_order", idx, exp_seq[k]);
            if (k > 0) check("B_gap", cyc - fall_cyc, G + 2);
            if (idx >= 0) set_word(idx, $urandom);
            if (k == 4) bus.req = '0;
        end
        wait_idle();

        // Move pointer to 2, then wrap-around with req=0011.
        bus.req = 4'b0010;
        wait_load(idx, w);
        check("C_pre", idx, 1);
        bus.req = '0;
        wait_idle();
        bus.req = 4'b0011;
        wait_load(idx, w);
        check("C_wrap0", idx, 0);
        wait_load(idx, w);
        check("C_wrap1", idx, 1);
        bus.req = '0;
        wait_idle();

        // en dropped while the word is on the wire, another request pending.
        bus.req = 4'b1100;
        wait_load(idx, w);
        check("D_first", idx, 2);
        bus.req = 4'b1000;
        tick(5);
        bus.en = 1'b0;
        wait_idle();
        loads = 0;
        sb    = 0;
        for (int k = 0; k < 100; k++) begin
            tick(1);
            if (bus.tx_load === 1'b1)    loads++;
            if (bus.sched_busy === 1'b1) sb++;
        end
        check("D_no_load", loads, 0);
        check("D_idle", sb, 0);
        bus.en = 1'b1;
        wait_load(idx, w);
        check("D_resume_latency", w, 1);
        check("D_resume", idx, 3);
        bus.req = '0;
        wait_idle();

        // Reset mid-GAP clears outputs and pointer.
        bus.req = 4'b0010;
        wait_load(idx, w);
        check("E_pre", idx, 1);
        bus.req = '0;
        tick(xmit_len + 150);
        check("E_in_gap", bus.sched_busy, 1'b1);
        bus.req = 4'b1010;
        Rst_n   = 1'b0;
        tick(1);
        check("E_rst_gnt",     bus.gnt,        4'b0000);
        check("E_rst_load",    bus.tx_load,    1'b0);
        check("E_rst_busy",    bus.sched_busy, 1'b0);
        check("E_rst_word",    bus.tx_word,    32'h0);
        Rst_n = 1'b1;
        wait_load(idx, w);
        check("E_after_rst", idx, 1);
        check("E_latency", w, 1);
        bus.req = '0;
        wait_idle();

        // Late tx_busy: no extra pulses while waiting for the start.
        xmit_delay = 5;
        bus.req    = 4'b0100;
        wait_load(idx, w);
        check("F_gnt", idx, 2);
        bus.req = '0;
        loads = 0;
        sb    = 0;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            if (bus.tx_load === 1'b1 || bus.gnt !== '0) loads++;
            if (bus.sched_busy === 1'b1) sb++;
        end
        check("F_no_extra", loads, 0);
        check("F_busy", sb, 6);
        wait_idle();
        xmit_delay = 1;

        // Randomized traffic against the model.
        loads = 0;
        guard = 0;
        while (loads < 20 && guard < 40000) begin
            tick(1);
            guard++;
            if (bus.tx_load === 1'b1) begin
                loads++;
                idx = onehot_idx(bus.gnt);
                if (idx >= 0 && ($urandom % 2) == 0) bus.req[idx] = 1'b0;
                if (idx >= 0) set_word(idx, $urandom);
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (!bus.req[i] && ($urandom % 16) == 0) begin
                        set_word(i, $urandom);
                        bus.req[i] = 1'b1;
                    end else if (bus.req[i] && ($urandom % 200) == 0) begin
                        bus.req[i] = 1'b0;
                    end
                end
            end
            if (bus.en && ($urandom % 600) == 0)       bus.en = 1'b0;
            else if (!bus.en && ($urandom % 50) == 0)  bus.en = 1'b1;
            if (bus.sched_busy === 1'b0) begin
                xmit_delay = 1 + int'($urandom % 3);
                xmit_len   = 10 + int'($urandom % 40);
            end
        end
        if (loads < 20) begin
            total++;
            bad++;
            $display("FAIL random_loads: got %0d loads expected 20", loads);
        end
        bus.req = '0;
        bus.en  = 1'b1;
        wait_idle();
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
